// File: rtl/Mesh.sv
// rtl/Mesh.sv - shared mesh link types and constants
package Mesh;

    localparam int SEQ_W         = 4;
    localparam int ACK_COUNT_MAX = 15;
    localparam int PKT_W         = 64;

    typedef struct packed {
        logic             valid;
        logic [PKT_W-1:0] packet;
        logic [SEQ_W-1:0] seq;
        logic             err;
    } LinkRx;

    typedef enum logic {
        RX_RUN  = 1'b0,
        RX_DROP = 1'b1
    } rx_state_e;

    function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] s);
        return s + SEQ_W'(1);
    endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// rtl/link_rx_fifo.sv - synchronous FIFO accepting a push on a full cycle that also pops
module link_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/replay_link_rx.sv
// rtl/replay_link_rx.sv - link retry receiver: sequence check, forwarding FIFO, ack/nack coalescing
module replay_link_rx
    import Mesh::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_MAX     = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int NACK_RETRY  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [PKT_W-1:0]  rx_packet,
    input  logic [SEQ_W-1:0]  rx_seq,
    input  logic              rx_err,
    output logic              out_valid,
    output logic [PKT_W-1:0]  out_packet,
    input  logic              out_ready,
    output logic              ack,
    output logic [SEQ_W-1:0]  ack_count,
    output logic              nack
);

    localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RT_W = $clog2(NACK_RETRY + 1);

    LinkRx            rx_s;
    rx_state_e        state_q, state_d;
    logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
    logic [SEQ_W-1:0] pending_q, pending_d;
    logic [AT_W-1:0]  ack_timer_q, ack_timer_d;
    logic [RT_W-1:0]  retry_timer_q, retry_timer_d;
    logic             ack_q, ack_d;
    logic [SEQ_W-1:0] ack_count_q, ack_count_d;
    logic             nack_q, nack_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             fifo_space;
    logic             good;
    logic             bad;
    logic             retry_due;
    logic             nack_fire;
    logic [SEQ_W-1:0] pend_inc;
    logic             fire_max;
    logic             fire_other;

    assign rx_s = '{valid: rx_valid, packet: rx_packet, seq: rx_seq, err: rx_err};

    assign out_valid  = ~fifo_empty;
    assign pop        = ~fifo_empty & out_ready;
    assign fifo_space = ~fifo_full | pop;
    assign good       = rx_s.valid & ~rx_s.err & (rx_s.seq == exp_seq_q) & fifo_space;
    assign bad        = rx_s.valid & ~good;
    assign retry_due  = (state_q == RX_DROP) & (retry_timer_q >= RT_W'(NACK_RETRY - 1));
    // A good packet while waiting out the retry interval makes the reissue moot.
    assign nack_fire  = ((state_q == RX_RUN) & bad) | (retry_due & ~good);

    // Hitting ACK_MAX counts this cycle's packet so the ack lands right after it;
    // timeout/nack acks retire what was already pending.
    assign pend_inc   = pending_q + SEQ_W'(good);
    assign fire_max   = (pend_inc == SEQ_W'(ACK_MAX));
    assign fire_other = (pending_q != '0) &
                        ((ack_timer_q >= AT_W'(ACK_TIMEOUT - 1)) | nack_fire);

    link_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (good),
        .push_data (rx_s.packet),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_packet)
    );

    // Next state of the RUN/DROP machine, sequence tracking and ack coalescing.
    always_comb begin
        state_d       = state_q;
        exp_seq_d     = exp_seq_q;
        retry_timer_d = '0;
        nack_d        = nack_fire;
        ack_d         = 1'b0;
        ack_count_d   = '0;
        pending_d     = pend_inc;
        ack_timer_d   = '0;

        if (good) begin
            state_d   = RX_RUN;
            exp_seq_d = seq_inc(exp_seq_q);
        end else if ((state_q == RX_RUN) && bad) begin
            state_d = RX_DROP;
        end

        if ((state_q == RX_DROP) && !good && !retry_due) begin
            retry_timer_d = retry_timer_q + RT_W'(1);
        end

        if (fire_max) begin
            ack_d       = 1'b1;
            ack_count_d = pend_inc;
            pending_d   = '0;
        end else if (fire_other) begin
            ack_d       = 1'b1;
            ack_count_d = pending_q;
            pending_d   = SEQ_W'(good);
            ack_timer_d = AT_W'(good);
        end else if (pend_inc != '0) begin
            ack_timer_d = ack_timer_q + AT_W'(1);
        end
    end

    // Single register bank for the FSM, counters and registered ack/nack outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RX_RUN;
            exp_seq_q     <= '0;
            pending_q     <= '0;
            ack_timer_q   <= '0;
            retry_timer_q <= '0;
            ack_q         <= 1'b0;
            ack_count_q   <= '0;
            nack_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_seq_q     <= exp_seq_d;
            pending_q     <= pending_d;
            ack_timer_q   <= ack_timer_d;
            retry_timer_q <= retry_timer_d;
            ack_q         <= ack_d;
            ack_count_q   <= ack_count_d;
            nack_q        <= nack_d;
        end
    end

    assign ack       = ack_q;
    assign ack_count = ack_count_q;
    assign nack      = nack_q;

endmodule
